ysyx_25040129_mem_arbiter: RTL and testbench

//  Shares the single MMU AXI-lite port between the IFU (read-only) and LSU (read/write) masters.

---
 rtl/ysyx_25040129_mem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_ysyx_25040129_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040129_mem_arbiter.sv
// Arbiter sharing the single MMU AXI-lite port between the IFU (read-only) and LSU (read/write).
// One transaction per registered grant; responses are routed only to the granted master.
module ysyx_25040129_mem_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] ifu_araddr,
    input  logic [31:0] ifu_arsatp,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    input  logic [2:0]  ifu_arsize,
    input  logic [7:0]  ifu_arlen,
    input  logic [1:0]  ifu_arburst,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    output logic        ifu_rlast,
    input  logic        ifu_rready,

    input  logic [31:0] lsu_araddr,
    input  logic [31:0] lsu_arsatp,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    input  logic [2:0]  lsu_arsize,
    input  logic [7:0]  lsu_arlen,
    input  logic [1:0]  lsu_arburst,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    output logic        lsu_rlast,
    input  logic        lsu_rready,
    input  logic [31:0] lsu_awaddr,
    input  logic [31:0] lsu_awsatp,
    input  logic        lsu_awvalid,
    output logic        lsu_awready,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wstrb,
    input  logic        lsu_wvalid,
    output logic        lsu_wready,
    output logic [1:0]  lsu_bresp,
    output logic        lsu_bvalid,
    input  logic        lsu_bready,

    output logic [31:0] out_araddr,
    output logic [31:0] out_arsatp,
    output logic        out_arvalid,
    input  logic        out_arready,
    output logic [2:0]  out_arsize,
    output logic [7:0]  out_arlen,
    output logic [1:0]  out_arburst,
    input  logic [31:0] out_rdata,
    input  logic [1:0]  out_rresp,
    input  logic        out_rvalid,
    input  logic        out_rlast,
    output logic        out_rready,
    output logic [31:0] out_awaddr,
    output logic [31:0] out_awsatp,
    output logic        out_awvalid,
    input  logic        out_awready,
    output logic [31:0] out_wdata,
    output logic [3:0]  out_wstrb,
    output logic        out_wvalid,
    input  logic        out_wready,
    input  logic [1:0]  out_bresp,
    input  logic        out_bvalid,
    output logic        out_bready
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RD_IFU = 2'd1;
    localparam logic [1:0] RD_LSU = 2'd2;
    localparam logic [1:0] WR_LSU = 2'd3;

    logic [1:0] state;
    logic [1:0] state_next;
    logic       ar_done;
    logic       aw_done;
    logic       w_done;
    logic       last_lsu;

    logic write_req;
    logic read_conflict;
    logic lsu_wins;

    assign write_req     = lsu_awvalid && lsu_wvalid;
    assign read_conflict = (state == IDLE) && !write_req && ifu_arvalid && lsu_arvalid;
    assign lsu_wins      = (ROUND_ROBIN == 1'b0) || !last_lsu;

    // Grant is decided only in IDLE; a write always beats an LSU read
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (write_req)
                    state_next = WR_LSU;
                else if (ifu_arvalid && lsu_arvalid)
                    state_next = lsu_wins ? RD_LSU : RD_IFU;
                else if (lsu_arvalid)
                    state_next = RD_LSU;
                else if (ifu_arvalid)
                    state_next = RD_IFU;
            end
            RD_IFU: if (out_rvalid && ifu_rready && out_rlast) state_next = IDLE;
            RD_LSU: if (out_rvalid && lsu_rready && out_rlast) state_next = IDLE;
            WR_LSU: if (out_bvalid && lsu_bready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ar_done  <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            last_lsu <= 1'b0;
        end else begin
            state <= state_next;
            if (read_conflict && ROUND_ROBIN)
                last_lsu <= lsu_wins;
            if (state_next == IDLE) begin
                ar_done <= 1'b0;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (out_arvalid && out_arready) ar_done <= 1'b1;
                if (out_awvalid && out_awready) aw_done <= 1'b1;
                if (out_wvalid && out_wready)   w_done  <= 1'b1;
            end
        end
    end

    // Data returns are broadcast; only the granted master ever sees a valid
    assign ifu_rdata = out_rdata;
    assign ifu_rresp = out_rresp;
    assign ifu_rlast = out_rlast;
    assign lsu_rdata = out_rdata;
    assign lsu_rresp = out_rresp;
    assign lsu_rlast = out_rlast;
    assign lsu_bresp = out_bresp;

    always_comb begin
        out_araddr  = 32'd0;
        out_arsatp  = 32'd0;
        out_arvalid = 1'b0;
        out_arsize  = 3'd0;
        out_arlen   = 8'd0;
        out_arburst = 2'd0;
        out_rready  = 1'b0;
        out_awaddr  = 32'd0;
        out_awsatp  = 32'd0;
        out_awvalid = 1'b0;
        out_wdata   = 32'd0;
        out_wstrb   = 4'd0;
        out_wvalid  = 1'b0;
        out_bready  = 1'b0;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        case (state)
            RD_IFU: begin
                out_araddr  = ifu_araddr;
                out_arsatp  = ifu_arsatp;
                out_arvalid = ifu_arvalid && !ar_done;
                out_arsize  = ifu_arsize;
                out_arlen   = ifu_arlen;
                out_arburst = ifu_arburst;
                ifu_arready = out_arready && !ar_done;
                ifu_rvalid  = out_rvalid;
                out_rready  = ifu_rready;
            end
            RD_LSU: begin
                out_araddr  = lsu_araddr;
                out_arsatp  = lsu_arsatp;
                out_arvalid = lsu_arvalid && !ar_done;
                out_arsize  = lsu_arsize;
                out_arlen   = lsu_arlen;
                out_arburst = lsu_arburst;
                lsu_arready = out_arready && !ar_done;
                lsu_rvalid  = out_rvalid;
                out_rready  = lsu_rready;
            end
            WR_LSU: begin
                out_awaddr  = lsu_awaddr;
                out_awsatp  = lsu_awsatp;
                out_awvalid = lsu_awvalid && !aw_done;
                out_wdata   = lsu_wdata;
                out_wstrb   = lsu_wstrb;
                out_wvalid  = lsu_wvalid && !w_done;
                lsu_awready = out_awready && !aw_done;
                lsu_wready  = out_wready && !w_done;
                lsu_bvalid  = out_bvalid;
                out_bready  = lsu_bready;
            end
            default: ;
        endcase
    end

    // A granted master must hold its request valid until the handshake completes
    a_ifu_ar_hold: assert property (@(posedge clk) disable iff (rst)
        (state == RD_IFU && !ar_done) |-> ifu_arvalid)
        else $error("ifu_arvalid dropped before AR handshake");
    a_lsu_ar_hold: assert property (@(posedge clk) disable iff (rst)
        (state == RD_LSU && !ar_done) |-> lsu_arvalid)
        else $error("lsu_arvalid dropped before AR handshake");
    a_lsu_aw_hold: assert property (@(posedge clk) disable iff (rst)
        (state == WR_LSU && !aw_done) |-> lsu_awvalid)
        else $error("lsu_awvalid dropped before AW handshake");
    a_lsu_w_hold: assert property (@(posedge clk) disable iff (rst)
        (state == WR_LSU && !w_done) |-> lsu_wvalid)
        else $error("lsu_wvalid dropped before W handshake");

endmodule

// File: tb/tb_ysyx_25040129_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter; the bench plays both masters and the MMU.
module tb_ysyx_25040129_mem_arbiter;

    localparam logic [31:0] ST_IDLE   = 32'd0;
    localparam logic [31:0] ST_WR_LSU = 32'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr, ifu_arsatp;
    logic        ifu_arvalid, ifu_arready;
    logic [2:0]  ifu_arsize;
    logic [7:0]  ifu_arlen;
    logic [1:0]  ifu_arburst;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid, ifu_rlast, ifu_rready;
    logic [31:0] lsu_araddr, lsu_arsatp;
    logic        lsu_arvalid, lsu_arready;
    logic [2:0]  lsu_arsize;
    logic [7:0]  lsu_arlen;
    logic [1:0]  lsu_arburst;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid, lsu_rlast, lsu_rready;
    logic [31:0] lsu_awaddr, lsu_awsatp;
    logic        lsu_awvalid, lsu_awready;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_wvalid, lsu_wready;
    logic [1:0]  lsu_bresp;
    logic        lsu_bvalid, lsu_bready;
    logic [31:0] out_araddr, out_arsatp;
    logic        out_arvalid, out_arready;
    logic [2:0]  out_arsize;
    logic [7:0]  out_arlen;
    logic [1:0]  out_arburst;
    logic [31:0] out_rdata;
    logic [1:0]  out_rresp;
    logic        out_rvalid, out_rlast, out_rready;
    logic [31:0] out_awaddr, out_awsatp;
    logic        out_awvalid, out_awready;
    logic [31:0] out_wdata;
    logic [3:0]  out_wstrb;
    logic        out_wvalid, out_wready;
    logic [1:0]  out_bresp;
    logic        out_bvalid, out_bready;

    int checks = 0;
    int errors = 0;
    int beats;

    ysyx_25040129_mem_arbiter #(.ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arsatp(ifu_arsatp), .ifu_arvalid(ifu_arvalid),
        .ifu_arready(ifu_arready), .ifu_arsize(ifu_arsize), .ifu_arlen(ifu_arlen),
        .ifu_arburst(ifu_arburst), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .ifu_rvalid(ifu_rvalid), .ifu_rlast(ifu_rlast), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arsatp(lsu_arsatp), .lsu_arvalid(lsu_arvalid),
        .lsu_arready(lsu_arready), .lsu_arsize(lsu_arsize), .lsu_arlen(lsu_arlen),
        .lsu_arburst(lsu_arburst), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_rvalid(lsu_rvalid), .lsu_rlast(lsu_rlast), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awsatp(lsu_awsatp), .lsu_awvalid(lsu_awvalid),
        .lsu_awready(lsu_awready), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_bresp(lsu_bresp),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .out_araddr(out_araddr), .out_arsatp(out_arsatp), .out_arvalid(out_arvalid),
        .out_arready(out_arready), .out_arsize(out_arsize), .out_arlen(out_arlen),
        .out_arburst(out_arburst), .out_rdata(out_rdata), .out_rresp(out_rresp),
        .out_rvalid(out_rvalid), .out_rlast(out_rlast), .out_rready(out_rready),
        .out_awaddr(out_awaddr), .out_awsatp(out_awsatp), .out_awvalid(out_awvalid),
        .out_awready(out_awready), .out_wdata(out_wdata), .out_wstrb(out_wstrb),
        .out_wvalid(out_wvalid), .out_wready(out_wready), .out_bresp(out_bresp),
        .out_bvalid(out_bvalid), .out_bready(out_bready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One cycle after the request is seen in IDLE, the granted master gets AR
    task automatic expectGrant(input string tag, input bit toIfu);
        @(negedge clk);
        #1;
        checkOutput({tag, "_ifu_arready"}, 32'(ifu_arready), 32'(toIfu));
        checkOutput({tag, "_lsu_arready"}, 32'(lsu_arready), 32'(!toIfu));
        checkOutput({tag, "_out_arvalid"}, 32'(out_arvalid), 32'd1);
    endtask

    // Single-beat read response after the AR handshake, then back to IDLE
    task automatic serveRead(input string tag, input bit toIfu, input logic [31:0] data, input int latency);
        @(negedge clk);
        if (toIfu) ifu_arvalid = 1'b0;
        else       lsu_arvalid = 1'b0;
        #1;
        checkOutput({tag, "_ar_dropped"}, 32'(out_arvalid), 32'd0);
        repeat (latency) @(negedge clk);
        out_rvalid = 1'b1;
        out_rdata  = data;
        out_rlast  = 1'b1;
        #1;
        checkOutput({tag, "_rvalid"}, 32'(toIfu ? ifu_rvalid : lsu_rvalid), 32'd1);
        checkOutput({tag, "_rdata"}, toIfu ? ifu_rdata : lsu_rdata, data);
        checkOutput({tag, "_other_rvalid"}, 32'(toIfu ? lsu_rvalid : ifu_rvalid), 32'd0);
        checkOutput({tag, "_rready"}, 32'(out_rready), 32'd1);
        @(negedge clk);
        out_rvalid = 1'b0;
        out_rlast  = 1'b0;
        #1;
        checkOutput({tag, "_idle"}, 32'(dut.state), ST_IDLE);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        ifu_araddr = '0; ifu_arsatp = '0; ifu_arvalid = 1'b0; ifu_arsize = 3'd2;
        ifu_arlen = '0; ifu_arburst = 2'd1; ifu_rready = 1'b1;
        lsu_araddr = '0; lsu_arsatp = '0; lsu_arvalid = 1'b0; lsu_arsize = 3'd2;
        lsu_arlen = '0; lsu_arburst = 2'd1; lsu_rready = 1'b1;
        lsu_awaddr = '0; lsu_awsatp = '0; lsu_awvalid = 1'b0;
        lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0; lsu_bready = 1'b0;
        out_arready = 1'b0; out_rdata = '0; out_rresp = '0; out_rvalid = 1'b0; out_rlast = 1'b0;
        out_awready = 1'b0; out_wready = 1'b0; out_bresp = '0; out_bvalid = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_out_arvalid", 32'(out_arvalid), 32'd0);
        checkOutput("rst_out_rready", 32'(out_rready), 32'd0);
        checkOutput("rst_out_bready", 32'(out_bready), 32'd0);
        checkOutput("rst_ifu_arready", 32'(ifu_arready), 32'd0);
        checkOutput("rst_lsu_awready", 32'(lsu_awready), 32'd0);
        rst = 1'b0;

        // IFU single read with a 3-cycle MMU response latency
        @(negedge clk);
        ifu_araddr = 32'h8000_0000; ifu_arsatp = 32'h8000_0123; ifu_arvalid = 1'b1;
        out_arready = 1'b1;
        #1;
        checkOutput("t1_idle_arvalid", 32'(out_arvalid), 32'd0);
        checkOutput("t1_idle_arsatp", out_arsatp, 32'd0);
        expectGrant("t1", 1'b1);
        checkOutput("t1_araddr", out_araddr, 32'h8000_0000);
        checkOutput("t1_arsatp", out_arsatp, 32'h8000_0123);
        serveRead("t1", 1'b1, 32'h0000_0013, 2);

        // Same-cycle IFU+LSU reads: LSU first after reset, IFU first on the repeat
        @(negedge clk);
        ifu_araddr = 32'h8000_0100; ifu_arvalid = 1'b1;
        lsu_araddr = 32'h8000_0200; lsu_arsatp = 32'h0000_0777; lsu_arvalid = 1'b1;
        expectGrant("t2a_lsu", 1'b0);
        checkOutput("t2a_araddr", out_araddr, 32'h8000_0200);
        serveRead("t2a_lsu", 1'b0, 32'h0000_0022, 0);
        expectGrant("t2a_ifu", 1'b1);
        serveRead("t2a_ifu", 1'b1, 32'h0000_0033, 0);
        @(negedge clk);
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        expectGrant("t2b_ifu", 1'b1);
        checkOutput("t2b_araddr", out_araddr, 32'h8000_0100);
        serveRead("t2b_ifu", 1'b1, 32'h0000_0044, 0);
        expectGrant("t2b_lsu", 1'b0);
        serveRead("t2b_lsu", 1'b0, 32'h0000_0055, 0);

        // Same-cycle LSU write and LSU read: write goes first
        @(negedge clk);
        lsu_awaddr = 32'h8000_1000; lsu_awsatp = 32'h8000_0456; lsu_awvalid = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_wvalid = 1'b1;
        lsu_araddr = 32'h8000_2000; lsu_arvalid = 1'b1;
        out_awready = 1'b1; out_wready = 1'b1; lsu_bready = 1'b1;
        #1;
        checkOutput("t3_idle_awvalid", 32'(out_awvalid), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("t3_awvalid", 32'(out_awvalid), 32'd1);
        checkOutput("t3_wvalid", 32'(out_wvalid), 32'd1);
        checkOutput("t3_no_arvalid", 32'(out_arvalid), 32'd0);
        checkOutput("t3_awaddr", out_awaddr, 32'h8000_1000);
        checkOutput("t3_awsatp", out_awsatp, 32'h8000_0456);
        checkOutput("t3_wdata", out_wdata, 32'hDEAD_BEEF);
        checkOutput("t3_wstrb", 32'(out_wstrb), 32'hF);
        @(negedge clk);
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; out_bvalid = 1'b1;
        #1;
        checkOutput("t3_bvalid", 32'(lsu_bvalid), 32'd1);
        checkOutput("t3_no_arvalid_b", 32'(out_arvalid), 32'd0);
        @(negedge clk);
        out_bvalid = 1'b0;
        #1;
        checkOutput("t3_idle", 32'(dut.state), ST_IDLE);
        expectGrant("t3_rd", 1'b0);
        serveRead("t3_rd", 1'b0, 32'h0000_0077, 0);
        out_awready = 1'b0; out_wready = 1'b0; lsu_bready = 1'b0;

        // Write where AW is accepted two cycles before W; B held off by bready
        @(negedge clk);
        lsu_awaddr = 32'h8000_1004; lsu_awvalid = 1'b1;
        lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'h3; lsu_wvalid = 1'b1;
        out_awready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("t4_awvalid", 32'(out_awvalid), 32'd1);
        checkOutput("t4_lsu_wready_lo", 32'(lsu_wready), 32'd0);
        @(negedge clk);
        lsu_awvalid = 1'b0;
        #1;
        checkOutput("t4_aw_dropped", 32'(out_awvalid), 32'd0);
        checkOutput("t4_wvalid_held", 32'(out_wvalid), 32'd1);
        @(negedge clk);
        out_wready = 1'b1;
        #1;
        checkOutput("t4_aw_still_low", 32'(out_awvalid), 32'd0);
        checkOutput("t4_lsu_wready", 32'(lsu_wready), 32'd1);
        @(negedge clk);
        lsu_wvalid = 1'b0; out_bvalid = 1'b1;
        #1;
        checkOutput("t4_w_dropped", 32'(out_wvalid), 32'd0);
        checkOutput("t4_bvalid", 32'(lsu_bvalid), 32'd1);
        checkOutput("t4_bready_lo", 32'(out_bready), 32'd0);
        @(negedge clk);
        #1;
        checkOutput("t4_hold_wr", 32'(dut.state), ST_WR_LSU);
        lsu_bready = 1'b1;
        #1;
        checkOutput("t4_bready", 32'(out_bready), 32'd1);
        @(negedge clk);
        out_bvalid = 1'b0; lsu_bready = 1'b0; out_awready = 1'b0; out_wready = 1'b0;
        #1;
        checkOutput("t4_idle", 32'(dut.state), ST_IDLE);
        checkOutput("t4_single_b", 32'(lsu_bvalid), 32'd0);

        // IFU 4-beat burst with toggling rready; LSU waits for rlast
        @(negedge clk);
        ifu_araddr = 32'h8000_0400; ifu_arlen = 8'd3; ifu_arvalid = 1'b1;
        expectGrant("t5_ifu", 1'b1);
        checkOutput("t5_arlen", 32'(out_arlen), 32'd3);
        lsu_araddr = 32'h8000_0500; lsu_arvalid = 1'b1;
        beats = 0;
        for (int c = 0; c < 20 && beats < 4; c++) begin
            @(negedge clk);
            if (c == 0) ifu_arvalid = 1'b0;
            ifu_rready = c[0];
            out_rvalid = 1'b1;
            out_rdata  = 32'h100 + beats;
            out_rlast  = (beats == 3);
            #1;
            checkOutput("t5_lsu_blocked", 32'(lsu_arready), 32'd0);
            if (ifu_rvalid && ifu_rready) begin
                checkOutput("t5_beat_data", ifu_rdata, 32'h100 + beats);
                checkOutput("t5_beat_rlast", 32'(ifu_rlast), 32'(beats == 3));
                beats++;
            end
        end
        checkOutput("t5_beat_count", 32'(beats), 32'd4);
        @(negedge clk);
        out_rvalid = 1'b0; out_rlast = 1'b0; ifu_rready = 1'b1;
        #1;
        checkOutput("t5_idle", 32'(dut.state), ST_IDLE);
        expectGrant("t5_lsu", 1'b0);
        serveRead("t5_lsu", 1'b0, 32'h0000_0088, 0);

        // Conflict sets last_lsu, then reset lands in the middle of an IFU burst
        @(negedge clk);
        ifu_araddr = 32'h8000_0600; ifu_arlen = 8'd3; ifu_arvalid = 1'b1;
        lsu_araddr = 32'h8000_0700; lsu_arvalid = 1'b1;
        expectGrant("t6_lsu", 1'b0);
        serveRead("t6_lsu", 1'b0, 32'h0000_0066, 0);
        expectGrant("t6_ifu", 1'b1);
        @(negedge clk);
        ifu_arvalid = 1'b0;
        out_rvalid = 1'b1; out_rdata = 32'h0000_0200; out_rlast = 1'b0;
        #1;
        checkOutput("t6_beat0", 32'(ifu_rvalid), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("t6_last_lsu_set", 32'(dut.last_lsu), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("t6_state", 32'(dut.state), ST_IDLE);
        checkOutput("t6_last_lsu", 32'(dut.last_lsu), 32'd0);
        checkOutput("t6_out_arvalid", 32'(out_arvalid), 32'd0);
        checkOutput("t6_out_rready", 32'(out_rready), 32'd0);
        checkOutput("t6_out_awvalid", 32'(out_awvalid), 32'd0);
        checkOutput("t6_out_wvalid", 32'(out_wvalid), 32'd0);
        checkOutput("t6_out_bready", 32'(out_bready), 32'd0);
        checkOutput("t6_ifu_rvalid", 32'(ifu_rvalid), 32'd0);
        checkOutput("t6_ifu_arready", 32'(ifu_arready), 32'd0);
        rst = 1'b0;
        out_rvalid = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
